// File: rtl/data_mem_bytelane_if.sv
// Request/response bundle for the byte-lane data memory.
// A request transfers on a posedge where req_valid && req_ready. A response transfers on a
// posedge where rsp_valid && rsp_ready. A valid side holds its payload stable until the
// transfer happens.
interface data_mem_bytelane_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_bytelane.sv
// Word-organised data memory with little-endian byte/half/word access and sign extension.
// It keeps one request outstanding and holds the response until the consumer takes it.
module data_mem_bytelane #(
   parameter int DEPTH_LOG2 = 16,
   parameter bit INIT_ZERO  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_mem_bytelane_if.slave   bus,
   output logic                 dbg_state
);

   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

   state_e                  state_q, state_d;
   logic                    accept, mem_en, req_err, out_of_range;
   logic [DEPTH_LOG2-1:0]   idx;
   logic [1:0]              lane;
   logic [3:0]              wr_be;
   logic [31:0]             wr_word;
   logic [31:0]             rd_word_q;
   logic                    err_q, load_q, signed_q;
   logic [1:0]              size_q, lane_q;
   logic [7:0]              sel_byte;
   logic [15:0]             sel_half;

   assign accept    = bus.req_valid && bus.req_ready;
   // Reset wins over a same-cycle accept, so nothing reaches the array while rst_n is low.
   assign mem_en    = accept && rst_n;
   assign idx       = bus.req_addr[DEPTH_LOG2+1:2];
   assign lane      = bus.req_addr[1:0];
   assign dbg_state = state_q;

   assign out_of_range = (bus.req_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
   always_comb begin
      req_err = out_of_range;
      case (bus.req_size)
         2'b01:   if (lane[0])        req_err = 1'b1;
         2'b10:   if (lane != 2'b00)  req_err = 1'b1;
         2'b11:                       req_err = 1'b1;
         default: ;
      endcase
   end

   // Store data is replicated across lanes; wr_be picks the lanes that actually change.
   always_comb begin
      wr_be   = 4'b0000;
      wr_word = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            wr_be   = 4'b0001 << lane;
            wr_word = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            wr_be   = lane[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{bus.req_wdata[15:0]}};
         end
         2'b10:   wr_be = 4'b1111;
         default: wr_be = 4'b0000;
      endcase
      if (!bus.req_we || req_err) wr_be = 4'b0000;
   end

   if (INIT_ZERO) begin : g_mem_zero
      logic [31:0] mem [2**DEPTH_LOG2] = '{default: '0};
      always_ff @(posedge clk) begin
         if (mem_en) begin
            for (int b = 0; b < 4; b++)
               if (wr_be[b]) mem[idx][b*8 +: 8] <= wr_word[b*8 +: 8];
            rd_word_q <= mem[idx];
         end
      end
   end else begin : g_mem_undef
      logic [31:0] mem [2**DEPTH_LOG2];
      always_ff @(posedge clk) begin
         if (mem_en) begin
            for (int b = 0; b < 4; b++)
               if (wr_be[b]) mem[idx][b*8 +: 8] <= wr_word[b*8 +: 8];
            rd_word_q <= mem[idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_d = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q  <= 1'b0;
         load_q <= 1'b0;
      end else if (accept) begin
         err_q    <= req_err;
         load_q   <= !bus.req_we && !req_err;
         size_q   <= bus.req_size;
         lane_q   <= lane;
         signed_q <= bus.req_signed;
      end
   end

   // Extraction runs on the captured word and controls, so the response stays stable.
   assign sel_byte = rd_word_q[lane_q*8 +: 8];
   assign sel_half = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];

   always_comb begin
      bus.rsp_rdata = 32'd0;
      if (load_q) begin
         case (size_q)
            2'b00:   bus.rsp_rdata = {{24{signed_q & sel_byte[7]}}, sel_byte};
            2'b01:   bus.rsp_rdata = {{16{signed_q & sel_half[15]}}, sel_half};
            default: bus.rsp_rdata = rd_word_q;
         endcase
      end
   end
   assign bus.rsp_err = err_q;

endmodule

// File: doc/data_mem_bytelane.md
DATA_MEM_BYTELANE -- requirements
Module: data_mem_bytelane

Interface
REQ-001 Parameter DEPTH_LOG2, default 16: number of 32-bit words is 2**DEPTH_LOG2.
REQ-002 Parameter INIT_ZERO, default 0: if 1, simulation initial contents are all zero, otherwise undefined.
REQ-003 clk  input  1  sole clock, all state updates on posedge clk.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-009 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts the response this cycle.
REQ-014 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 rsp_err  output  1  request was misaligned, illegal size or out of range.

Function
REQ-016 A request is accepted on a posedge where req_valid && req_ready is true.
REQ-017 The FSM has exactly two states: IDLE (req_ready=1, rsp_valid=0) and RESP (req_ready=0, rsp_valid=1).
REQ-018 Transitions: IDLE->RESP on accept; RESP->IDLE when rsp_ready=1; otherwise the state holds.
REQ-019 At most one request is outstanding; no new request is accepted in the cycle the response is consumed (req_ready is low throughout RESP).
REQ-020 Latency: a request accepted at edge N produces rsp_valid=1 after edge N, and the response is held stable until consumed.
REQ-021 Word index = req_addr[DEPTH_LOG2+1:2]; byte lane = req_addr[1:0]; little-endian (lane 0 = bits [7:0]).
REQ-022 Error conditions:
- req_size=11.
- Halfword with req_addr[0]=1.
- Word with req_addr[1:0]!=00.
- Any req_addr bit above DEPTH_LOG2+1 set.
REQ-023 An erroring request: no memory write, rsp_err=1, rsp_rdata=0.
REQ-024 Stores write only the addressed lanes at the accept edge, selected by lane:
- Byte: lane k = req_wdata[7:0].
- Half: lanes {a1,0}/{a1,1} = req_wdata[15:0].
- Word: all lanes = req_wdata.
Other lanes are unchanged.
REQ-025 Loads capture the addressed word at the accept edge and extract the lane(s): byte -> 8 bits, half -> 16 bits, word -> 32 bits.
REQ-026 Extension: if req_signed=1, the MSB of the extracted field is replicated; otherwise zeros are filled; req_signed is ignored for word loads.
REQ-027 Operands are captured at the accept edge; input changes afterwards do not affect the response.
REQ-028 A store followed by a load to the same word returns the updated data (storage is written before the later load is accepted).
REQ-029 Memory contents are never altered by reset.

Reset
REQ-030 When rst_n=0 at a posedge: state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 after the edge.
REQ-031 Reset has priority over accept and consume in the same cycle; a request presented with rst_n=0 is not accepted and performs no write.
REQ-032 Reset while in RESP discards the pending response; its store, if any, has already completed.

Verification
REQ-033 Store word 0xDEADBEEF @0x10, load word @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid one cycle after accept.
REQ-034 Then store byte 0x7F @0x12, load signed byte @0x13 -> 0xFFFFFFDE; unsigned half @0x12 -> 0x0000DE7F; word @0x10 -> 0xDE7FBEEF.
REQ-035 Misaligned cases:
- Load half @0x11 -> rsp_err=1, rsp_rdata=0.
- Store word @0x16 -> rsp_err=1, and a later load word @0x14 is unchanged.
- req_size=11 -> rsp_err=1.
REQ-036 Backpressure: hold rsp_ready=0 for 5 cycles after accept -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; req_valid asserted during this time is not accepted.
REQ-037 Reset mid-RESP: rst_n=0 for one edge -> rsp_valid=0, req_ready=1 next cycle, and previously stored data remains readable.
REQ-038 Out of range with DEPTH_LOG2=4: load @0x40 -> rsp_err=1; load @0x3C -> rsp_err=0.
